// File: rtl/uart_alu_pkg.sv
// Shared FSM encoding and byte-sizing helper for the UART ALU frame controller.
// RX_CHK only exists when UART_ALU_CHECKSUM_EN is defined.
package uart_alu_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RX_OP1  = 3'd1;
    localparam logic [2:0] ST_RX_OP2  = 3'd2;
`ifdef UART_ALU_CHECKSUM_EN
    localparam logic [2:0] ST_RX_CHK  = 3'd3;
`endif
    localparam logic [2:0] ST_EXEC    = 3'd4;
    localparam logic [2:0] ST_TX_SEND = 3'd5;
    localparam logic [2:0] ST_TX_ACK  = 3'd6;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        RX_OP1  = ST_RX_OP1,
        RX_OP2  = ST_RX_OP2,
`ifdef UART_ALU_CHECKSUM_EN
        RX_CHK  = ST_RX_CHK,
`endif
        EXEC    = ST_EXEC,
        TX_SEND = ST_TX_SEND,
        TX_ACK  = ST_TX_ACK
    } state_e;

    function automatic int unsigned bytes_for(input int unsigned width);
        return (width + BYTE_W - 1) / BYTE_W;
    endfunction

endpackage

// File: rtl/uart_alu_frame_ctrl_if.sv
// Byte-stream, transmitter handshake and ALU operand/result bundle.
// slave: the frame controller; master: the surrounding UART/ALU environment.
interface uart_alu_frame_ctrl_if #(
    parameter int unsigned NB_OP   = 6,
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OUT  = 16
);
    logic [7:0]         i_rx_data;
    logic               i_rx_done;
    logic               i_tx_busy;
    logic [NB_OUT-1:0]  i_result;
    logic [NB_OP-1:0]   o_opcode;
    logic [NB_DATA-1:0] o_operand1;
    logic [NB_DATA-1:0] o_operand2;
    logic               o_data_valid;
    logic               o_tx_start;
    logic [7:0]         o_tx_data;
    logic               o_frame_error;
    logic               o_busy;

    modport slave (
        input  i_rx_data, i_rx_done, i_tx_busy, i_result,
        output o_opcode, o_operand1, o_operand2, o_data_valid,
               o_tx_start, o_tx_data, o_frame_error, o_busy
    );

    modport master (
        output i_rx_data, i_rx_done, i_tx_busy, i_result,
        input  o_opcode, o_operand1, o_operand2, o_data_valid,
               o_tx_start, o_tx_data, o_frame_error, o_busy
    );
endinterface

// File: rtl/rx_gap_timer.sv
// Inter-byte gap counter: cleared by a byte or when disabled, expires after TIMEOUT_CYCLES-1.
module rx_gap_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 500000
)(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // A byte on the boundary cycle wins, so clear masks expiry.
    assign o_expired = i_enable && !i_clear && (cnt == LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt <= '0;
        end else if (i_clear || !i_enable || o_expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_alu_frame_ctrl.sv
// Multi-byte frame controller between the UART byte streams and the combinational ALU.
// Define UART_ALU_CHECKSUM_EN for an XOR checksum byte on receive and transmit.
module uart_alu_frame_ctrl
    import uart_alu_pkg::*;
#(
    parameter int unsigned NB_OP          = 6,
    parameter int unsigned NB_DATA        = 8,
    parameter int unsigned NB_OUT         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 500000
)(
    input logic                 i_clk,
    input logic                 i_reset,
    uart_alu_frame_ctrl_if.slave bus
);
    localparam int unsigned OP_BYTES  = bytes_for(NB_DATA);
    localparam int unsigned RES_BYTES = bytes_for(NB_OUT);
`ifdef UART_ALU_CHECKSUM_EN
    localparam int unsigned TX_BYTES  = RES_BYTES + 1;
`else
    localparam int unsigned TX_BYTES  = RES_BYTES;
`endif
    localparam int unsigned OP_W  = OP_BYTES * BYTE_W;
    localparam int unsigned RES_W = RES_BYTES * BYTE_W;

    state_e             state;
    logic [7:0]         idx;
    logic               tx_acked;
    logic [NB_OP-1:0]   opcode_stg;
    logic [OP_W-1:0]    op1_stg;
    logic [OP_W-1:0]    op2_stg;
    logic [RES_W-1:0]   res_reg;
    logic [BYTE_W-1:0]  tx_byte;
    logic               op_last;
    logic               tx_last;
    logic               gap_en;
    logic               gap_expired;

    assign op_last     = (32'(idx) == OP_BYTES - 1);
    assign tx_last     = (32'(idx) == TX_BYTES - 1);
    assign bus.o_busy  = (state != IDLE);

`ifdef UART_ALU_CHECKSUM_EN
    logic [BYTE_W-1:0] chk_acc;
    logic [BYTE_W-1:0] res_xor;

    assign gap_en = (state == RX_OP1) || (state == RX_OP2) || (state == RX_CHK);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            chk_acc <= '0;
        end else if (bus.i_rx_done) begin
            chk_acc <= (state == IDLE) ? bus.i_rx_data : (chk_acc ^ bus.i_rx_data);
        end
    end

    always_comb begin
        res_xor = '0;
        for (int unsigned k = 0; k < RES_BYTES; k++) begin
            res_xor = res_xor ^ res_reg[k*BYTE_W +: BYTE_W];
        end
    end
`else
    logic [OP_W-1:0] op2_merged;

    assign gap_en = (state == RX_OP1) || (state == RX_OP2);

    // Final operand byte is committed in the same edge it arrives.
    always_comb begin
        op2_merged = op2_stg;
        op2_merged[idx*BYTE_W +: BYTE_W] = bus.i_rx_data;
    end
`endif

    always_comb begin
        tx_byte = '0;
        for (int unsigned k = 0; k < RES_BYTES; k++) begin
            if (32'(idx) == k) tx_byte = res_reg[k*BYTE_W +: BYTE_W];
        end
`ifdef UART_ALU_CHECKSUM_EN
        if (32'(idx) == RES_BYTES) tx_byte = res_xor;
`endif
    end

    rx_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (bus.i_rx_done),
        .i_enable (gap_en),
        .o_expired(gap_expired)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state             <= IDLE;
            idx               <= '0;
            tx_acked          <= 1'b0;
            opcode_stg        <= '0;
            op1_stg           <= '0;
            op2_stg           <= '0;
            res_reg           <= '0;
            bus.o_opcode      <= '0;
            bus.o_operand1    <= '0;
            bus.o_operand2    <= '0;
            bus.o_data_valid  <= 1'b0;
            bus.o_tx_start    <= 1'b0;
            bus.o_tx_data     <= '0;
            bus.o_frame_error <= 1'b0;
        end else begin
            bus.o_data_valid  <= 1'b0;
            bus.o_tx_start    <= 1'b0;
            bus.o_frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_rx_done) begin
                        opcode_stg <= bus.i_rx_data[NB_OP-1:0];
                        idx        <= '0;
                        state      <= RX_OP1;
                    end
                end
                RX_OP1: begin
                    if (bus.i_rx_done) begin
                        op1_stg[idx*BYTE_W +: BYTE_W] <= bus.i_rx_data;
                        if (op_last) begin
                            idx   <= '0;
                            state <= RX_OP2;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (gap_expired) begin
                        bus.o_frame_error <= 1'b1;
                        state             <= IDLE;
                    end
                end
                RX_OP2: begin
                    if (bus.i_rx_done) begin
                        op2_stg[idx*BYTE_W +: BYTE_W] <= bus.i_rx_data;
                        if (op_last) begin
`ifdef UART_ALU_CHECKSUM_EN
                            state <= RX_CHK;
`else
                            bus.o_opcode     <= opcode_stg;
                            bus.o_operand1   <= op1_stg[NB_DATA-1:0];
                            bus.o_operand2   <= op2_merged[NB_DATA-1:0];
                            bus.o_data_valid <= 1'b1;
                            state            <= EXEC;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (gap_expired) begin
                        bus.o_frame_error <= 1'b1;
                        state             <= IDLE;
                    end
                end
`ifdef UART_ALU_CHECKSUM_EN
                RX_CHK: begin
                    if (bus.i_rx_done) begin
                        if (bus.i_rx_data == chk_acc) begin
                            bus.o_opcode     <= opcode_stg;
                            bus.o_operand1   <= op1_stg[NB_DATA-1:0];
                            bus.o_operand2   <= op2_stg[NB_DATA-1:0];
                            bus.o_data_valid <= 1'b1;
                            state            <= EXEC;
                        end else begin
                            bus.o_frame_error <= 1'b1;
                            state             <= IDLE;
                        end
                    end else if (gap_expired) begin
                        bus.o_frame_error <= 1'b1;
                        state             <= IDLE;
                    end
                end
`endif
                EXEC: begin
                    res_reg  <= RES_W'(bus.i_result);
                    idx      <= '0;
                    tx_acked <= 1'b0;
                    state    <= TX_SEND;
                end
                TX_SEND: begin
                    if (!bus.i_tx_busy) begin
                        bus.o_tx_data  <= tx_byte;
                        bus.o_tx_start <= 1'b1;
                        state          <= TX_ACK;
                    end
                end
                TX_ACK: begin
                    // Last byte: after busy is seen, wait for it to drop before leaving.
                    if (!tx_acked) begin
                        if (bus.i_tx_busy) begin
                            if (tx_last) begin
                                tx_acked <= 1'b1;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= TX_SEND;
                            end
                        end
                    end else if (!bus.i_tx_busy) begin
                        tx_acked <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_alu_frame_ctrl.md
Name: uart_alu_frame_ctrl

Overview:
Frame controller between the UART byte streams (receiver/transmitter) and the combinational ALU. It generalises the 10-bit single-word interface to multi-byte frames: an opcode byte, then N-byte operands, with the full NB_OUT result returned as multiple bytes, LSB first. It adds a transmitter handshake, an inter-byte timeout and frame-error reporting. It sits between uart_receiver/uart_transmitter and ALU in the UART top.

Parameters:
NB_OP, 6, opcode width; must be ≤ 8.
NB_DATA, 8, operand width; OP_BYTES = ceil(NB_DATA/8).
NB_OUT, 16, ALU result width; RES_BYTES = ceil(NB_OUT/8).
TIMEOUT_CYCLES, 500000, maximum number of idle clocks allowed between bytes of one frame.

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_rx_data  in  8  received byte, valid when i_rx_done is high
i_rx_done  in  1  one-cycle pulse per received byte
i_tx_busy  in  1  transmitter busy
i_result  in  NB_OUT  ALU result (combinational from the o_operand*/o_opcode outputs)
o_opcode  out  NB_OP  registered opcode
o_operand1  out  NB_DATA  registered operand 1
o_operand2  out  NB_DATA  registered operand 2
o_data_valid  out  1  one-cycle pulse: operands complete
o_tx_start  out  1  one-cycle pulse to the transmitter
o_tx_data  out  8  byte to transmit; held until the transmitter acknowledges
o_frame_error  out  1  one-cycle pulse on frame abort
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Clock i_clk; reset i_reset is asynchronous and active-high. While reset is asserted, all outputs and internal registers are 0 and the state is IDLE.
- Reset asserted mid-frame or mid-transmission aborts immediately. No o_frame_error is raised.
- Frame format: byte0 = opcode (bits [NB_OP-1:0] kept, upper bits ignored), then OP_BYTES bytes of operand 1 (LSB first), then OP_BYTES bytes of operand 2.
- When NB_DATA is not a multiple of 8, excess bits in the last operand byte are discarded.
- States: IDLE → RX_OP1 → RX_OP2 → EXEC → TX_SEND ⇄ TX_ACK → IDLE.
- IDLE: on i_rx_done, capture the opcode into a staging register and move to RX_OP1.
- RX_OP1 / RX_OP2: a byte counter advances on each i_rx_done.
- Operands are assembled in staging registers. o_opcode/o_operand* update only in the cycle after the final byte's i_rx_done; o_data_valid pulses in that same cycle. The outputs then hold until the next completed frame.
- EXEC: lasts one cycle after o_data_valid. At its clock edge, i_result is latched into the result register and the byte index is cleared.
- TX_SEND: when i_tx_busy is 0, drive o_tx_data = result byte[idx] and pulse o_tx_start for one cycle, then go to TX_ACK.
- TX_ACK: wait for i_tx_busy = 1, then go to TX_SEND for the next byte. After byte RES_BYTES-1 is acknowledged, wait for i_tx_busy = 0 and go to IDLE.
- When NB_OUT is not a multiple of 8, the last result byte is zero-padded.
- Timeout: in RX_OP1/RX_OP2 the gap counter clears on each i_rx_done. If it reaches TIMEOUT_CYCLES-1 without a byte, the block pulses o_frame_error and returns to IDLE. Outputs are not updated.
- A byte arriving in the same cycle as the timeout boundary is accepted; the byte wins over the timeout.
- i_rx_done during EXEC/TX_SEND/TX_ACK is ignored; the byte is dropped. The next frame starts only from IDLE.
- Latency from the final rx byte to the first o_tx_start is 3 cycles if the transmitter is idle.

Optional Feature:
Macro UART_ALU_CHECKSUM_EN.
- Defined: adds state RX_CHK after RX_OP2. The extra frame byte must equal the XOR of all preceding frame bytes.
  - Mismatch: pulse o_frame_error, return to IDLE, no o_data_valid.
  - Match: behaviour continues as normal.
  - After the result bytes, one extra byte is transmitted: the XOR of all result bytes.
- Undefined: no checksum byte is expected or sent, and RX_CHK does not exist.

Decomposition:
- Package uart_alu_pkg:
  - state enum;
  - BYTE_W = 8;
  - function bytes_for(width) computing ceil(width/8);
  - OP_BYTES/RES_BYTES derived from it.
- Sub-module rx_gap_timer: clear/enable/expire counter, parametrised by TIMEOUT_CYCLES.

Test Plan:
Bench ALU stub: i_result = zero-extended operand1 + operand2.
- Defaults; bytes 0x20,0x05,0x03 → o_opcode=0x20, op1=0x05, op2=0x03; o_data_valid 1 cycle after the third i_rx_done; tx bytes 0x08 then 0x00.
- NB_DATA=16, NB_OUT=24; bytes 0x20,0x34,0x12,0x01,0x00 → op1=0x1234, op2=0x0001; tx bytes 0x35,0x12,0x00.
- Bytes 0x20,0x05 then silence for TIMEOUT_CYCLES (set to 100) → single o_frame_error pulse, no o_data_valid, outputs unchanged; next full frame is processed normally.
- i_tx_busy forced high for 1000 cycles after EXEC → no o_tx_start until it is released; bytes then go out in order, one start per busy cycle.
- Byte injected during TX_ACK → ignored, result bytes unaffected; reset asserted in TX_ACK → all outputs 0 asynchronously, IDLE after release.
- With UART_ALU_CHECKSUM_EN: frame 0x20,0x05,0x03,0x26 → tx 0x08,0x00,0x08. Same frame with checksum 0x27 → o_frame_error, no tx.
